// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge
// Purpose  : Latches one CPU load/store, decodes it to one of four APB slots
//            and runs the APB SETUP/ACCESS handshake. Optional access-phase
//            timeout is enabled with the APB_TIMEOUT_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
    parameter logic [15:0] BASE_HI = 16'h1000,
    parameter int          NUM_SLV = 4
`ifdef APB_TIMEOUT_EN
    ,
    parameter int          TIMEOUT_CYC = 16
`endif
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        transfer,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err,
    output logic [31:0] PADDR,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic        PENABLE,
    output logic        PSEL0,
    output logic        PSEL1,
    output logic        PSEL2,
    output logic        PSEL3,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic        PREADY0,
    input  logic        PREADY1,
    input  logic        PREADY2,
    input  logic        PREADY3
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_slot;
    logic               r_hit;
    logic [NUM_SLV-1:0] r_psel;
    logic [NUM_SLV-1:0] w_psel_next;
    logic               w_hit;
    logic [1:0]         w_slot;
    logic [1:0]         w_next_slot;
    logic               w_next_hit;
    logic               w_pready;
    logic [31:0]        w_prdata;
    logic               w_latch;
    logic               w_timeout;

    assign w_hit  = (addr[31:16] == BASE_HI) && (addr[15:14] == 2'b00);
    assign w_slot = addr[13:12];
    assign busy   = (r_state != IDLE);

    assign PSEL0 = r_psel[0];
    assign PSEL1 = r_psel[1];
    assign PSEL2 = r_psel[2];
    assign PSEL3 = r_psel[3];

    always_comb begin
        w_pready = 1'b0;
        w_prdata = 32'h0;
        case (r_slot)
            2'd0:    begin w_pready = PREADY0; w_prdata = PRDATA0; end
            2'd1:    begin w_pready = PREADY1; w_prdata = PRDATA1; end
            2'd2:    begin w_pready = PREADY2; w_prdata = PRDATA2; end
            default: begin w_pready = PREADY3; w_prdata = PRDATA3; end
        endcase
    end

`ifdef APB_TIMEOUT_EN
    logic [7:0] r_wait_cnt;

    // Counter is held at zero outside ACCESS, so it starts at zero on entry
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_wait_cnt <= 8'd0;
        end else if (r_state != ACCESS) begin
            r_wait_cnt <= 8'd0;
        end else if (!w_pready) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    assign w_timeout = (r_state == ACCESS) && !w_pready &&
                       (r_wait_cnt == 8'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        ready   = 1'b0;
        err     = 1'b0;
        rdata   = 32'h0;
        case (r_state)
            IDLE: begin
                if (transfer) begin
                    w_latch = 1'b1;
                    w_next  = w_hit ? SETUP : ERROR;
                end
            end
            SETUP: w_next = ACCESS;
            ACCESS: begin
                if (w_pready) begin
                    ready = 1'b1;
                    if (!PWRITE) rdata = w_prdata;
                    // A request in the completing cycle is taken without an IDLE bubble
                    if (transfer) begin
                        w_latch = 1'b1;
                        w_next  = w_hit ? SETUP : ERROR;
                    end else begin
                        w_next = IDLE;
                    end
                end else if (w_timeout) begin
                    ready  = 1'b1;
                    err    = 1'b1;
                    rdata  = 32'hDEAD_BEEF;
                    w_next = IDLE;
                end
            end
            ERROR: begin
                ready  = 1'b1;
                err    = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_next_slot = w_latch ? w_slot : r_slot;
        w_next_hit  = w_latch ? w_hit  : r_hit;
        w_psel_next = '0;
        if (((w_next == SETUP) || (w_next == ACCESS)) && w_next_hit) begin
            w_psel_next[w_next_slot] = 1'b1;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= IDLE;
            PADDR   <= 32'h0;
            PWDATA  <= 32'h0;
            PWRITE  <= 1'b0;
            PENABLE <= 1'b0;
            r_psel  <= '0;
            r_slot  <= 2'd0;
            r_hit   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                PADDR  <= addr;
                PWDATA <= wdata;
                PWRITE <= write;
                r_slot <= w_slot;
                r_hit  <= w_hit;
            end
            r_psel  <= w_psel_next;
            PENABLE <= (w_next == ACCESS);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_bridge
// Purpose  : Directed self-checking bench for apb_master_bridge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        transfer, write;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        ready, busy, err;
    logic [31:0] PADDR, PWDATA;
    logic        PWRITE, PENABLE;
    logic        PSEL0, PSEL1, PSEL2, PSEL3;
    logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;
    logic        PREADY0, PREADY1, PREADY2, PREADY3;
    wire  [3:0]  psel_v = {PSEL3, PSEL2, PSEL1, PSEL0};

    int errors = 0;
    int checks = 0;

    apb_master_bridge dut (
        .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy),
        .err(err), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PENABLE(PENABLE), .PSEL0(PSEL0), .PSEL1(PSEL1), .PSEL2(PSEL2),
        .PSEL3(PSEL3), .PRDATA0(PRDATA0), .PRDATA1(PRDATA1),
        .PRDATA2(PRDATA2), .PRDATA3(PRDATA3), .PREADY0(PREADY0),
        .PREADY1(PREADY1), .PREADY2(PREADY2), .PREADY3(PREADY3)
    );

    always #5 PCLK = ~PCLK;

    // Inputs change 1 ns after the rising edge; checks follow 1 ns later
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic test_reset();
        PRESET = 1'b1; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
        PRDATA0 = '0; PRDATA1 = '0; PRDATA2 = '0; PRDATA3 = '0;
        PREADY0 = 1'b0; PREADY1 = 1'b0; PREADY2 = 1'b0; PREADY3 = 1'b0;
        tick(); tick(); #1;
        checks++; if (psel_v !== 4'b0000) begin errors++; $display("FAIL reset_psel: got %b expected 0000", psel_v); end
        checks++; if ({PENABLE, PWRITE, busy, ready, err} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {PENABLE, PWRITE, busy, ready, err}); end
        checks++; if ({PADDR, PWDATA, rdata} !== 96'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {PADDR, PWDATA, rdata}); end
        tick();
        PRESET = 1'b0;
    endtask

    task automatic test_store();
        tick();
        transfer = 1'b1; write = 1'b1; addr = 32'h1000_0000; wdata = 32'h0000_00FF;
        tick();
        transfer = 1'b0; wdata = 32'h1234_5678; #1;
        checks++; if ({psel_v, PENABLE, busy} !== 6'b0001_0_1) begin errors++; $display("FAIL store_setup: got %b expected 000101", {psel_v, PENABLE, busy}); end
        checks++; if ({PWDATA, PWRITE, ready} !== {32'hFF, 1'b1, 1'b0}) begin errors++; $display("FAIL store_pwdata: got %h/%b/%b expected ff/1/0", PWDATA, PWRITE, ready); end
        tick(); #1;
        checks++; if ({psel_v, PENABLE, ready} !== 6'b0001_1_0) begin errors++; $display("FAIL store_access1: got %b expected 000110", {psel_v, PENABLE, ready}); end
        tick();
        PREADY0 = 1'b1; #1;
        checks++; if ({psel_v, PENABLE, ready, err, rdata} !== {6'b0001_1_1, 1'b0, 32'h0}) begin errors++; $display("FAIL store_ready: got %b/%b/%h expected 000111/0/0", {psel_v, PENABLE, ready}, err, rdata); end
        tick();
        PREADY0 = 1'b0; #1;
        checks++; if ({psel_v, PENABLE, busy, ready} !== 7'b0) begin errors++; $display("FAIL store_idle: got %b expected 0000000", {psel_v, PENABLE, busy, ready}); end
    endtask

    task automatic test_load();
        PREADY0 = 1'b1; PRDATA0 = 32'h0000_005A; PREADY1 = 1'b1; PRDATA1 = 32'hBAD0_BAD0;
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_0008;
        tick();
        transfer = 1'b0; #1;
        checks++; if ({ready, PENABLE, psel_v} !== 6'b0_0_0001) begin errors++; $display("FAIL load_setup: got %b expected 000001", {ready, PENABLE, psel_v}); end
        checks++; if (PADDR[3:2] !== 2'd2) begin errors++; $display("FAIL load_paddr: got %0d expected 2", PADDR[3:2]); end
        tick(); #1;
        checks++; if ({ready, err, rdata} !== {2'b10, 32'h5A}) begin errors++; $display("FAIL load_rdata: got %b/%b/%h expected 1/0/0000005a", ready, err, rdata); end
        tick(); #1;
        checks++; if ({ready, busy, rdata} !== 34'h0) begin errors++; $display("FAIL load_after: got %b/%b/%h expected 0/0/0", ready, busy, rdata); end
        PREADY0 = 1'b0; PREADY1 = 1'b0;
    endtask

    task automatic test_wait_states();
        PREADY0 = 1'b1;
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_2004;
        tick();
        transfer = 1'b0; addr = 32'h0; #1;
        checks++; if (psel_v !== 4'b0100) begin errors++; $display("FAIL wait_setup_psel: got %b expected 0100", psel_v); end
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            checks++; if ({psel_v, PENABLE, ready, PADDR} !== {6'b0100_1_0, 32'h1000_2004}) begin errors++; $display("FAIL wait_cycle%0d: got %b/%h expected 010010/10002004", i, {psel_v, PENABLE, ready}, PADDR); end
        end
        tick();
        PREADY2 = 1'b1; PRDATA2 = 32'hCAFE_0002; #1;
        checks++; if ({ready, err, rdata, PADDR} !== {2'b10, 32'hCAFE_0002, 32'h1000_2004}) begin errors++; $display("FAIL wait_ready: got %b/%b/%h/%h expected 1/0/cafe0002/10002004", ready, err, rdata, PADDR); end
        tick();
        PREADY2 = 1'b0; PREADY0 = 1'b0; #1;
        checks++; if ({psel_v, busy} !== 5'b0) begin errors++; $display("FAIL wait_idle: got %b expected 00000", {psel_v, busy}); end
    endtask

    task automatic test_unmapped();
        logic [31:0] bad_addr [2];
        bad_addr[0] = 32'h2000_0000;
        bad_addr[1] = 32'h1000_4000;
        for (int i = 0; i < 2; i++) begin
            transfer = 1'b1; write = 1'b1; addr = bad_addr[i]; wdata = 32'h55;
            tick();
            transfer = 1'b0; #1;
            checks++; if ({psel_v, PENABLE, ready, err, busy, rdata} !== {8'b0000_0_1_1_1, 32'h0}) begin errors++; $display("FAIL unmapped%0d_err: got %b/%h expected 00000111/0", i, {psel_v, PENABLE, ready, err, busy}, rdata); end
            tick(); #1;
            checks++; if ({ready, err, busy} !== 3'b000) begin errors++; $display("FAIL unmapped%0d_idle: got %b expected 000", i, {ready, err, busy}); end
        end
    endtask

    task automatic test_back_to_back();
        transfer = 1'b1; write = 1'b1; addr = 32'h1000_0010; wdata = 32'hA5;
        tick();
        transfer = 1'b0;
        tick();
        PREADY0 = 1'b1;
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_1004; #1;
        checks++; if ({ready, psel_v} !== 5'b1_0001) begin errors++; $display("FAIL b2b_first_ready: got %b expected 10001", {ready, psel_v}); end
        tick();
        transfer = 1'b0; PREADY0 = 1'b0; #1;
        checks++; if ({psel_v, PENABLE, busy, ready} !== 7'b0010_0_1_0) begin errors++; $display("FAIL b2b_setup: got %b expected 0010010", {psel_v, PENABLE, busy, ready}); end
        checks++; if ({PADDR, PWRITE} !== {32'h1000_1004, 1'b0}) begin errors++; $display("FAIL b2b_latch: got %h/%b expected 10001004/0", PADDR, PWRITE); end
        tick();
        PREADY1 = 1'b1; PRDATA1 = 32'h00C0_FFEE; #1;
        checks++; if ({ready, PENABLE, rdata} !== {2'b11, 32'h00C0_FFEE}) begin errors++; $display("FAIL b2b_second: got %b/%h expected 11/00c0ffee", {ready, PENABLE}, rdata); end
        tick();
        PREADY1 = 1'b0; #1;
        checks++; if ({psel_v, busy} !== 5'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 00000", {psel_v, busy}); end
    endtask

    task automatic test_reset_mid();
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_3000;
        tick();
        transfer = 1'b0;
        tick(); #1;
        checks++; if ({psel_v, PENABLE} !== 5'b1000_1) begin errors++; $display("FAIL rstmid_access: got %b expected 10001", {psel_v, PENABLE}); end
        PREADY3 = 1'b1; PRESET = 1'b1; #1;
        checks++; if ({psel_v, PENABLE, busy, ready, err} !== 8'b0) begin errors++; $display("FAIL rstmid_abort: got %b expected 00000000", {psel_v, PENABLE, busy, ready, err}); end
        checks++; if (PADDR !== 32'h0) begin errors++; $display("FAIL rstmid_paddr: got %h expected 0", PADDR); end
        tick();
        PRESET = 1'b0; PREADY3 = 1'b0; #1;
        checks++; if ({busy, ready} !== 2'b00) begin errors++; $display("FAIL rstmid_after: got %b expected 00", {busy, ready}); end
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout();
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_1000;
        tick();
        transfer = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick(); #1;
            checks++; if ({ready, err, PENABLE} !== 3'b001) begin errors++; $display("FAIL timeout_wait%0d: got %b expected 001", i, {ready, err, PENABLE}); end
        end
        tick(); #1;
        checks++; if ({ready, err, rdata} !== {2'b11, 32'hDEAD_BEEF}) begin errors++; $display("FAIL timeout_fire: got %b/%b/%h expected 1/1/deadbeef", ready, err, rdata); end
        tick(); #1;
        checks++; if ({psel_v, PENABLE, busy, ready} !== 7'b0) begin errors++; $display("FAIL timeout_idle: got %b expected 0000000", {psel_v, PENABLE, busy, ready}); end
    endtask
`endif

    initial begin
        test_reset();
        test_store();
        test_load();
        test_wait_states();
        test_unmapped();
        test_back_to_back();
        test_reset_mid();
`ifdef APB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Bridges the RISC-V core's data-memory bus to the APB peripheral bus.
- Latches one CPU load/store, decodes its address to one of four peripheral slots, and drives the APB SETUP/ACCESS sequence.
- Returns PRDATA/PREADY from the selected slave to the core.
- Sits directly upstream of every APB peripheral, including the GPIO, UART and timer slaves.

Parameters:
- BASE_HI, 16'h1000, required value of addr[31:16] for the APB region.
- NUM_SLV, 4, number of decoded slots (fixed at 4; values other than 4 are unsupported).

Ports:
- PCLK  input  1  APB/system clock, rising edge.
- PRESET  input  1  asynchronous active-high reset.
- transfer  input  1  single-cycle CPU request strobe.
- write  input  1  1 = store, 0 = load; sampled with transfer.
- addr  input  32  CPU byte address; sampled with transfer.
- wdata  input  32  store data; sampled with transfer.
- rdata  output  32  load data; valid only while ready=1.
- ready  output  1  one-cycle completion pulse.
- busy  output  1  transaction in flight (state != IDLE).
- err  output  1  one-cycle pulse for an unmapped address (with ready).
- PADDR  output  32  APB address.
- PWRITE  output  1  APB direction.
- PWDATA  output  32  APB write data.
- PENABLE  output  1  APB access phase.
- PSEL0..PSEL3  output  1 each  slave selects, one-hot or all zero.
- PRDATA0..PRDATA3  input  32 each  slave read data.
- PREADY0..PREADY3  input  1 each  slave ready.

Behaviour:
Clock and reset:
- Single clock PCLK; reset PRESET is asynchronous, active-high.
- On PRESET, state = IDLE and all registers clear: PADDR = 0, PWDATA = 0, PWRITE = 0, PENABLE = 0, PSEL0..3 = 0, busy = 0, ready = 0, err = 0, rdata = 0.
- Reset asserted mid-transfer aborts the transfer immediately; no ready pulse is produced.

Decode:
- hit = (addr[31:16] == BASE_HI) && (addr[15:12] < 4); slot = addr[13:12].
- Decode is done at latch time and stored in a 2-bit slot register plus a hit flag.

Latch:
- While in IDLE, transfer=1 latches addr into PADDR, wdata into PWDATA, write into PWRITE, plus the decode result.

FSM states IDLE, SETUP, ACCESS, ERROR:
- IDLE: transfer && hit -> SETUP; transfer && !hit -> ERROR; otherwise stay.
- SETUP, one cycle: PSEL[slot] = 1, PENABLE = 0; then -> ACCESS unconditionally.
- ACCESS: PSEL[slot] = 1, PENABLE = 1. Wait states are unlimited; PADDR, PWDATA and PWRITE stay stable.
  - When PREADY[slot] = 1: ready = 1 (combinational); rdata = PRDATA[slot] for loads, 0 for stores.
  - Next state is SETUP if transfer=1 in that same cycle (back-to-back: the new request is latched on that edge), else IDLE.
- ERROR, one cycle: ready = 1, err = 1, rdata = 0, no PSEL asserted; -> IDLE.

Outputs and ignored inputs:
- PSEL and PENABLE are registered outputs; ready, err and rdata are combinational from state and the selected slave's inputs.
- transfer is ignored in SETUP, ERROR, and ACCESS cycles without PREADY[slot]; the core must hold off while busy=1.
- PREADY and PRDATA of unselected slaves are ignored.

Latency:
- Minimum 3 cycles from the transfer edge to the ready pulse: SETUP, ACCESS, then a registered slave PREADY (zero-wait slaves give 2).

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT_CYC (default 16) and an 8-bit wait counter, cleared on entry to ACCESS and incremented each ACCESS cycle without PREADY[slot].
  - When the counter reaches TIMEOUT_CYC-1 without PREADY[slot]: ready = 1, err = 1, rdata = 32'hDEAD_BEEF, PSEL/PENABLE drop, -> IDLE.
  - PREADY arriving in the same cycle as timeout wins: normal completion, err = 0.
- Undefined: no counter; ACCESS waits indefinitely.

Test Plan:
- Store 32'h0000_00FF to addr 32'h1000_0000 (slot 0, GPIO CR), slave PREADY one cycle after PENABLE -> PSEL0 high 3 cycles, PENABLE high 2, PWDATA = 32'hFF, ready pulse at cycle 3, err = 0.
- Load from 32'h1000_0008 with PRDATA0 = 32'h0000_005A -> rdata = 32'h5A exactly in the ready cycle; PADDR[3:2] = 2'd2.
- Load from 32'h1000_2004 (slot 2), slave holds PREADY low 5 cycles -> PSEL2 only, PADDR stable throughout, ready on the 6th ACCESS cycle.
- Store to 32'h2000_0000 -> no PSEL asserted, ready = 1 and err = 1 one cycle after the request, busy for 1 cycle.
- Back-to-back: new transfer to slot 1 in the completing ACCESS cycle of a slot-0 transfer -> next cycle SETUP with PSEL1 = 1, PSEL0 = 0, no IDLE bubble.
- PRESET pulse during ACCESS -> all PSEL/PENABLE = 0 asynchronously, no ready pulse; with APB_TIMEOUT_EN, slave never ready -> err = 1, rdata = 32'hDEAD_BEEF after 16 ACCESS cycles.
